// File: rtl/sd_key_pkg.sv
// -----------------------------------------------------------------------------
// sd_key_pkg
// Shared definitions for the serial key responder and the host-side sequencer
// model: unlock FSM state encoding, default protocol constants, and the key bit
// and LFSR step functions.
// -----------------------------------------------------------------------------
package sd_key_pkg;

    typedef enum logic [2:0] {
        ST_U0,
        ST_U1,
        ST_U2,
        ST_U3,
        ST_STREAM
    } state_t;

    localparam int          DEF_FRAME_LEN  = 48;
    localparam logic [15:0] DEF_UNLOCK_SEQ = 16'h28A9;
    localparam logic [5:0]  DEF_LFSR_SEED  = 6'h21;
    localparam logic [3:0]  DEF_ABORT_NIB  = 4'hF;

    // Key bit presented to the host for a given LFSR state.
    function automatic logic key_bit(input logic [5:0] s);
        return s[0] ^ s[3] ^ s[5];
    endfunction

    // One shift of the 6-bit LFSR.
    function automatic logic [5:0] lfsr_next(input logic [5:0] s);
        return {s[4:0], s[5] ^ s[4]};
    endfunction

endpackage

// File: rtl/sd_key_lfsr.sv
// -----------------------------------------------------------------------------
// sd_key_lfsr
// Holds the 6-bit key LFSR and the registered serial key bit derived from it.
// A load takes priority over a step; both update the key bit on the same edge
// so the output always reflects the state the LFSR is moving to.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high (LFSR <- SEED, bit <- 0)
//   i_load     in   load i_load_val into the LFSR
//   i_load_val in   6-bit value to load
//   i_step     in   advance the LFSR by one shift
//   o_bit      out  registered key bit
// -----------------------------------------------------------------------------
module sd_key_lfsr
    import sd_key_pkg::*;
#(
    parameter logic [5:0] SEED = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [5:0] i_load_val,
    input  logic       i_step,
    output logic       o_bit
);

    logic [5:0] r_lfsr;
    logic [5:0] w_lfsr_step;

    assign w_lfsr_step = lfsr_next(r_lfsr);

    // LFSR state and the key bit that goes with the new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
            o_bit  <= 1'b0;
        end else if (i_load) begin
            r_lfsr <= i_load_val;
            o_bit  <= key_bit(i_load_val);
        end else if (i_step) begin
            r_lfsr <= w_lfsr_step;
            o_bit  <= key_bit(w_lfsr_step);
        end
    end

endmodule

// File: rtl/sd_key_responder.sv
// -----------------------------------------------------------------------------
// sd_key_responder
// Responder end of the address-strobed serial key protocol. Host reads of the
// card window carry command nibbles on address bits 7..4; after the four-nibble
// unlock sequence the block streams LFSR-derived key bits, one per host read,
// for FRAME_LEN reads or until the abort nibble is seen.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus_stb             one-cycle pulse per completed host bus cycle
//   bus_sel_n           card select, active low
//   bus_a13, bus_a12    address decode bits (window is a13=0, a12=1)
//   bus_nib             command nibble (address bits 7..4)
//   bus_r_w             1 = read cycle
//   seed_ld, seed_in    seed register load (ignored while streaming)
//   sd_out              registered serial key bit
//   sd_oe, unlocked     high while streaming
//   frame_done          one-cycle pulse when a frame completes
//   bit_cnt             bits consumed in the current frame
// -----------------------------------------------------------------------------
module sd_key_responder
    import sd_key_pkg::*;
#(
    parameter int          FRAME_LEN  = DEF_FRAME_LEN,
    parameter logic [15:0] UNLOCK_SEQ = DEF_UNLOCK_SEQ,
    parameter logic [5:0]  LFSR_SEED  = DEF_LFSR_SEED,
    parameter logic [3:0]  ABORT_NIB  = DEF_ABORT_NIB
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_stb,
    input  logic       bus_sel_n,
    input  logic       bus_a13,
    input  logic       bus_a12,
    input  logic [3:0] bus_nib,
    input  logic       bus_r_w,
    input  logic       seed_ld,
    input  logic [5:0] seed_in,
    output logic       sd_out,
    output logic       sd_oe,
    output logic       unlocked,
    output logic       frame_done,
    output logic [7:0] bit_cnt
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_seed;
    logic       r_stream;
    logic       w_acc;
    logic [3:0] w_exp_nib;
    logic       w_enter;
    logic       w_step;
    logic       w_frame_end;
    logic       w_abort;
    logic       w_seed_wr;
    logic [5:0] w_seed_guarded;
    logic [5:0] w_seed_eff;

    assign w_acc = bus_stb & ~bus_sel_n & ~bus_a13 & bus_a12 & bus_r_w;

    // An all-zero seed would lock the LFSR at zero forever.
    assign w_seed_guarded = (seed_in == 6'h00) ? 6'h01 : seed_in;
    assign w_seed_wr      = seed_ld && (r_state != ST_STREAM);
    // A load coinciding with the unlocking read must seed that very frame.
    assign w_seed_eff     = w_seed_wr ? w_seed_guarded : r_seed;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_U0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Unlock sequence matching and stream control. On a mismatch only the
    // first unlock nibble is considered as a restart point.
    always_comb begin
        w_state_next = r_state;
        w_enter      = 1'b0;
        w_step       = 1'b0;
        w_frame_end  = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_U1:   w_exp_nib = UNLOCK_SEQ[11:8];
            ST_U2:   w_exp_nib = UNLOCK_SEQ[7:4];
            ST_U3:   w_exp_nib = UNLOCK_SEQ[3:0];
            default: w_exp_nib = UNLOCK_SEQ[15:12];
        endcase
        if (w_acc) begin
            case (r_state)
                ST_U0, ST_U1, ST_U2, ST_U3: begin
                    if (bus_nib == w_exp_nib) begin
                        case (r_state)
                            ST_U0:   w_state_next = ST_U1;
                            ST_U1:   w_state_next = ST_U2;
                            ST_U2:   w_state_next = ST_U3;
                            default: begin
                                w_state_next = ST_STREAM;
                                w_enter      = 1'b1;
                            end
                        endcase
                    end else if (bus_nib == UNLOCK_SEQ[15:12]) begin
                        w_state_next = ST_U1;
                    end else begin
                        w_state_next = ST_U0;
                    end
                end
                ST_STREAM: begin
                    if (bus_nib == ABORT_NIB) begin
                        w_state_next = ST_U0;
                        w_abort      = 1'b1;
                    end else begin
                        w_step = 1'b1;
                        if (bit_cnt == LAST_IDX) begin
                            w_state_next = ST_U0;
                            w_frame_end  = 1'b1;
                        end
                    end
                end
                default: w_state_next = ST_U0;
            endcase
        end
    end

    // Seed register, bit counter, frame pulse and stream-active flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed     <= LFSR_SEED;
            bit_cnt    <= 8'd0;
            frame_done <= 1'b0;
            r_stream   <= 1'b0;
        end else begin
            if (w_seed_wr) begin
                r_seed <= w_seed_guarded;
            end
            if (w_enter || w_frame_end || w_abort) begin
                bit_cnt <= 8'd0;
            end else if (w_step) begin
                bit_cnt <= bit_cnt + 8'd1;
            end
            frame_done <= w_frame_end;
            r_stream   <= (w_state_next == ST_STREAM);
        end
    end

    assign sd_oe    = r_stream;
    assign unlocked = r_stream;

    sd_key_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_enter),
        .i_load_val (w_seed_eff),
        .i_step     (w_step),
        .o_bit      (sd_out)
    );

endmodule

// File: tb/tb_sd_key_responder.sv
// -----------------------------------------------------------------------------
// tb_sd_key_responder
// Directed scenario bench for sd_key_responder: unlock, streaming, restart on
// mismatch, full frame, abort, ignored bus cycles, seed handling and reset.
// -----------------------------------------------------------------------------
module tb_sd_key_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_stb;
    logic       bus_sel_n;
    logic       bus_a13;
    logic       bus_a12;
    logic [3:0] bus_nib;
    logic       bus_r_w;
    logic       seed_ld;
    logic [5:0] seed_in;
    logic       sd_out;
    logic       sd_oe;
    logic       unlocked;
    logic       frame_done;
    logic [7:0] bit_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    sd_key_responder dut (
        .clk        (clk),
        .rst        (rst),
        .bus_stb    (bus_stb),
        .bus_sel_n  (bus_sel_n),
        .bus_a13    (bus_a13),
        .bus_a12    (bus_a12),
        .bus_nib    (bus_nib),
        .bus_r_w    (bus_r_w),
        .seed_ld    (seed_ld),
        .seed_in    (seed_in),
        .sd_out     (sd_out),
        .sd_oe      (sd_oe),
        .unlocked   (unlocked),
        .frame_done (frame_done),
        .bit_cnt    (bit_cnt)
    );

    // Reference model of the key generator.
    function automatic logic mBit(input logic [5:0] s);
        return s[5] ^ s[3] ^ s[0];
    endfunction

    function automatic logic [5:0] mNext(input logic [5:0] s);
        logic [5:0] n;
        n = s << 1;
        n[0] = s[5] ^ s[4];
        return n;
    endfunction

    // One host bus cycle; outputs are sampled on the falling edge that ends it.
    task automatic busCycle(input logic selN, input logic a13, input logic a12,
                            input logic rw, input logic [3:0] nib,
                            input logic ld, input logic [5:0] seedV);
        @(negedge clk);
        bus_stb   = 1'b1;
        bus_sel_n = selN;
        bus_a13   = a13;
        bus_a12   = a12;
        bus_r_w   = rw;
        bus_nib   = nib;
        seed_ld   = ld;
        seed_in   = seedV;
        @(negedge clk);
        bus_stb   = 1'b0;
        bus_sel_n = 1'b1;
        seed_ld   = 1'b0;
    endtask

    task automatic doRead(input logic [3:0] nib);
        busCycle(1'b0, 1'b0, 1'b1, 1'b1, nib, 1'b0, 6'h00);
    endtask

    task automatic doUnlock();
        doRead(4'h2);
        doRead(4'h8);
        doRead(4'hA);
        doRead(4'h9);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic loadSeed(input logic [5:0] v);
        @(negedge clk);
        seed_ld = 1'b1;
        seed_in = v;
        @(negedge clk);
        seed_ld = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        doUnlock();
        doRead(4'h0);
        doReset();
        testsRun++; if (sd_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_sd_out: got %b want 0", sd_out); end
        testsRun++; if (sd_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_sd_oe: got %b want 0", sd_oe); end
        testsRun++; if (unlocked !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_unlocked: got %b want 0", unlocked); end
        testsRun++; if (frame_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done); end
        testsRun++; if (bit_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
    endtask

    task automatic test_unlock();
        doReset();
        doRead(4'h2);
        doRead(4'h8);
        doRead(4'hA);
        testsRun++; if (unlocked !== 1'b0) begin testsFailed++; $display("[TB] FAIL unlock_early: got %b want 0", unlocked); end
        doRead(4'h9);
        testsRun++; if (unlocked !== 1'b1) begin testsFailed++; $display("[TB] FAIL unlock_unlocked: got %b want 1", unlocked); end
        testsRun++; if (sd_oe !== 1'b1) begin testsFailed++; $display("[TB] FAIL unlock_sd_oe: got %b want 1", sd_oe); end
        testsRun++; if (sd_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL unlock_sd_out: got %b want 0", sd_out); end
        testsRun++; if (bit_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL unlock_bit_cnt: got %0d want 0", bit_cnt); end
    endtask

    task automatic test_stream();
        doRead(4'h0);
        testsRun++; if (sd_out !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream1_sd_out: got %b want 1", sd_out); end
        testsRun++; if (bit_cnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL stream1_bit_cnt: got %0d want 1", bit_cnt); end
        doRead(4'h3);
        testsRun++; if (sd_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream2_sd_out: got %b want 0", sd_out); end
        testsRun++; if (bit_cnt !== 8'd2) begin testsFailed++; $display("[TB] FAIL stream2_bit_cnt: got %0d want 2", bit_cnt); end
    endtask

    task automatic test_restart();
        logic [3:0] seq [6];
        seq = '{4'h2, 4'h8, 4'h2, 4'h8, 4'hA, 4'h9};
        doReset();
        for (int i = 0; i < 6; i++) begin
            doRead(seq[i]);
            if (i == 4) begin
                testsRun++; if (unlocked !== 1'b0) begin testsFailed++; $display("[TB] FAIL restart_early: got %b want 0", unlocked); end
            end
        end
        testsRun++; if (unlocked !== 1'b1) begin testsFailed++; $display("[TB] FAIL restart_unlocked: got %b want 1", unlocked); end
        testsRun++; if (sd_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL restart_sd_out: got %b want 0", sd_out); end
    endtask

    task automatic test_frame();
        logic [5:0] m;
        doReset();
        doUnlock();
        m = 6'h21;
        for (int i = 0; i < 48; i++) begin
            doRead(4'(i % 15));
            m = mNext(m);
            if (i < 47) begin
                testsRun++; if (sd_out !== mBit(m)) begin testsFailed++; $display("[TB] FAIL frame_sd_out[%0d]: got %b want %b", i, sd_out, mBit(m)); end
                testsRun++; if (bit_cnt !== 8'(i + 1)) begin testsFailed++; $display("[TB] FAIL frame_bit_cnt[%0d]: got %0d want %0d", i, bit_cnt, i + 1); end
                testsRun++; if (frame_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL frame_done_early[%0d]: got %b want 0", i, frame_done); end
                testsRun++; if (sd_oe !== 1'b1) begin testsFailed++; $display("[TB] FAIL frame_sd_oe[%0d]: got %b want 1", i, sd_oe); end
            end
        end
        testsRun++; if (frame_done !== 1'b1) begin testsFailed++; $display("[TB] FAIL frame_done_pulse: got %b want 1", frame_done); end
        testsRun++; if (sd_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL frame_end_sd_oe: got %b want 0", sd_oe); end
        testsRun++; if (unlocked !== 1'b0) begin testsFailed++; $display("[TB] FAIL frame_end_unlocked: got %b want 0", unlocked); end
        testsRun++; if (bit_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL frame_end_bit_cnt: got %0d want 0", bit_cnt); end
        @(negedge clk);
        testsRun++; if (frame_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL frame_done_width: got %b want 0", frame_done); end
        doRead(4'h0);
        testsRun++; if (sd_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL frame_relock: got %b want 0", sd_oe); end
    endtask

    task automatic test_abort();
        doReset();
        doUnlock();
        for (int i = 0; i < 5; i++) doRead(4'h1);
        testsRun++; if (bit_cnt !== 8'd5) begin testsFailed++; $display("[TB] FAIL abort_pre_cnt: got %0d want 5", bit_cnt); end
        doRead(4'hF);
        testsRun++; if (sd_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_sd_oe: got %b want 0", sd_oe); end
        testsRun++; if (unlocked !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_unlocked: got %b want 0", unlocked); end
        testsRun++; if (frame_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_frame_done: got %b want 0", frame_done); end
        @(negedge clk);
        testsRun++; if (frame_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_frame_done_late: got %b want 0", frame_done); end
    endtask

    task automatic test_ignored();
        logic [3:0] seq [4];
        seq = '{4'h2, 4'h8, 4'hA, 4'h9};
        doReset();
        for (int i = 0; i < 4; i++) busCycle(1'b0, 1'b0, 1'b1, 1'b0, seq[i], 1'b0, 6'h00);
        for (int i = 0; i < 4; i++) busCycle(1'b1, 1'b0, 1'b1, 1'b1, seq[i], 1'b0, 6'h00);
        for (int i = 0; i < 4; i++) busCycle(1'b0, 1'b1, 1'b1, 1'b1, seq[i], 1'b0, 6'h00);
        for (int i = 0; i < 4; i++) busCycle(1'b0, 1'b0, 1'b0, 1'b1, seq[i], 1'b0, 6'h00);
        testsRun++; if (unlocked !== 1'b0) begin testsFailed++; $display("[TB] FAIL ignored_unlock: got %b want 0", unlocked); end
        doRead(4'h2);
        doRead(4'h8);
        busCycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 6'h00);
        busCycle(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 6'h00);
        doRead(4'hA);
        doRead(4'h9);
        testsRun++; if (unlocked !== 1'b1) begin testsFailed++; $display("[TB] FAIL ignored_mid_seq: got %b want 1", unlocked); end
        doRead(4'h0);
        busCycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 6'h00);
        busCycle(1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 6'h00);
        busCycle(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 6'h00);
        testsRun++; if (bit_cnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL ignored_stream_cnt: got %0d want 1", bit_cnt); end
        testsRun++; if (sd_out !== 1'b1) begin testsFailed++; $display("[TB] FAIL ignored_stream_bit: got %b want 1", sd_out); end
        testsRun++; if (sd_oe !== 1'b1) begin testsFailed++; $display("[TB] FAIL ignored_stream_oe: got %b want 1", sd_oe); end
    endtask

    task automatic test_seed();
        logic exp [3];
        exp = '{1'b0, 1'b0, 1'b1};
        doReset();
        loadSeed(6'h00);
        doUnlock();
        testsRun++; if (sd_out !== 1'b1) begin testsFailed++; $display("[TB] FAIL seed0_sd_out: got %b want 1", sd_out); end
        for (int i = 0; i < 3; i++) begin
            doRead(4'h0);
            testsRun++; if (sd_out !== exp[i]) begin testsFailed++; $display("[TB] FAIL seed0_step[%0d]: got %b want %b", i, sd_out, exp[i]); end
        end
        loadSeed(6'h3E);
        doRead(4'hF);
        doUnlock();
        testsRun++; if (sd_out !== 1'b1) begin testsFailed++; $display("[TB] FAIL seed_ld_in_stream: got %b want 1", sd_out); end
        for (int i = 0; i < 3; i++) doRead(4'h0);
        testsRun++; if (sd_out !== 1'b1) begin testsFailed++; $display("[TB] FAIL seed_pre_rst_bit: got %b want 1", sd_out); end
        testsRun++; if (bit_cnt !== 8'd3) begin testsFailed++; $display("[TB] FAIL seed_pre_rst_cnt: got %0d want 3", bit_cnt); end
        doReset();
        testsRun++; if (sd_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_sd_out: got %b want 0", sd_out); end
        testsRun++; if (sd_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_sd_oe: got %b want 0", sd_oe); end
        testsRun++; if (unlocked !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_unlocked: got %b want 0", unlocked); end
        testsRun++; if (bit_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL midrst_bit_cnt: got %0d want 0", bit_cnt); end
        doRead(4'h2);
        doRead(4'h8);
        doRead(4'hA);
        busCycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 1'b1, 6'h0C);
        testsRun++; if (sd_out !== 1'b1) begin testsFailed++; $display("[TB] FAIL seed_same_cycle: got %b want 1", sd_out); end
        testsRun++; if (unlocked !== 1'b1) begin testsFailed++; $display("[TB] FAIL seed_same_cycle_unl: got %b want 1", unlocked); end
        doRead(4'h0);
        testsRun++; if (sd_out !== 1'b1) begin testsFailed++; $display("[TB] FAIL seed_same_cycle_step: got %b want 1", sd_out); end
    endtask

    initial begin
        rst       = 1'b1;
        bus_stb   = 1'b0;
        bus_sel_n = 1'b1;
        bus_a13   = 1'b0;
        bus_a12   = 1'b1;
        bus_nib   = 4'h0;
        bus_r_w   = 1'b1;
        seed_ld   = 1'b0;
        seed_in   = 6'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_unlock();
        test_stream();
        test_restart();
        test_frame();
        test_abort();
        test_ignored();
        test_seed();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
